// File: rtl/axi2ahb_rctrl_if.sv
// Signal bundle between the AXI read-command decoder, the AHB bus and the read-data stage.
// The master modport is the bridge's view; slave is the environment's view.
interface axi2ahb_rctrl_if #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 32
);
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [AXI_ID_WIDTH-1:0]   cmd_id_i;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i;
  logic [7:0]                cmd_len_i;
  logic [2:0]                cmd_size_i;
  logic [1:0]                cmd_burst_i;
  logic [AXI_ADDR_WIDTH-1:0] HADDR;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [2:0]                HBURST;
  logic                      HREADY;
  logic                      HRESP;
  logic                      ctrl_rdata_ready_i;
  logic                      ctrl_rdata_valid_o;
  logic                      ctrl_rdata_last_o;
  logic [AXI_ID_WIDTH-1:0]   cmd_id_o;
  logic                      cmd_error_o;

  modport master (
    input  cmd_valid_i, cmd_id_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
    input  HREADY, HRESP, ctrl_rdata_ready_i,
    output cmd_ready_o, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
    output ctrl_rdata_valid_o, ctrl_rdata_last_o, cmd_id_o, cmd_error_o
  );

  modport slave (
    output cmd_valid_i, cmd_id_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
    output HREADY, HRESP, ctrl_rdata_ready_i,
    input  cmd_ready_o, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
    input  ctrl_rdata_valid_o, ctrl_rdata_last_o, cmd_id_o, cmd_error_o
  );
endinterface

// File: rtl/axi2ahb_rctrl.sv
// Read-path control of the AXI-to-AHB bridge: issues AHB address phases for one AXI read
// command at a time and flags each data-phase beat (or synthesised error beat) downstream.
module axi2ahb_rctrl #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  axi2ahb_rctrl_if.master bus
);
  localparam int unsigned MaxSize = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [AXI_ADDR_WIDTH-1:0] AddrOne = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StAddr, StDrain, StErrWait, StErrFill} state_e;

  state_e                    r_state, w_state_d;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [7:0]                r_len, r_cnt, w_cnt_d;
  logic [2:0]                r_size, w_cmd_size;
  logic [1:0]                r_burst;
  logic                      r_first, w_first_d;
  logic                      r_nonseq, w_nonseq_d;
  logic                      r_dvalid, w_dvalid_d;
  logic                      r_dlast, w_dlast_d;
  logic                      w_capture, w_issue, w_herr;
  logic [1:0]                w_htrans;
  logic                      w_valid, w_last, w_err;
  logic [AXI_ADDR_WIDTH-1:0] w_incr, w_seq_addr, w_wrap_mask, w_next_addr;
  logic                      w_wrap_ok, w_next_nonseq;

  assign w_cmd_size = (bus.cmd_size_i > 3'(MaxSize)) ? 3'(MaxSize) : bus.cmd_size_i;

  // Address of the following beat, and whether AHB sees it as a new (NONSEQ) sequence.
  assign w_incr      = AddrOne << r_size;
  assign w_seq_addr  = r_addr + w_incr;
  assign w_wrap_ok   = (r_burst == 2'b10) &&
                       (r_len == 8'd1 || r_len == 8'd3 || r_len == 8'd7 || r_len == 8'd15);
  assign w_wrap_mask = ((AXI_ADDR_WIDTH'(r_len) + AddrOne) << r_size) - AddrOne;

  always_comb begin
    w_next_addr = w_seq_addr;
    if (r_burst == 2'b00) begin
      w_next_addr = r_addr;
    end else if (w_wrap_ok) begin
      w_next_addr = (r_addr & ~w_wrap_mask) | (w_seq_addr & w_wrap_mask);
    end
  end

  assign w_next_nonseq = (w_next_addr != w_seq_addr) ||
                         (w_next_addr[AXI_ADDR_WIDTH-1:10] != r_addr[AXI_ADDR_WIDTH-1:10]);

  // First cycle of a two-cycle AHB error response on the outstanding data phase.
  assign w_herr = r_dvalid && bus.HRESP && !bus.HREADY;

  always_comb begin
    w_state_d  = r_state;
    w_addr_d   = r_addr;
    w_cnt_d    = r_cnt;
    w_first_d  = r_first;
    w_nonseq_d = r_nonseq;
    w_dvalid_d = r_dvalid;
    w_dlast_d  = r_dlast;
    w_capture  = 1'b0;
    w_issue    = 1'b0;
    w_htrans   = TransIdle;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_err      = 1'b0;

    case (r_state)
      StIdle: begin
        if (bus.cmd_valid_i) begin
          w_capture  = 1'b1;
          w_addr_d   = bus.cmd_addr_i;
          w_cnt_d    = bus.cmd_len_i;
          w_first_d  = 1'b1;
          w_nonseq_d = 1'b0;
          w_state_d  = StAddr;
        end
      end
      StAddr: begin
        w_valid = r_dvalid;
        w_last  = r_dlast;
        if (!bus.ctrl_rdata_ready_i) begin
          w_htrans = r_first ? TransIdle : TransBusy;
        end else begin
          w_htrans = (r_first || r_nonseq) ? TransNonseq : TransSeq;
          w_issue  = bus.HREADY;
        end
        if (w_herr) begin
          w_state_d = StErrWait;
        end else if (w_issue) begin
          w_addr_d   = w_next_addr;
          w_nonseq_d = w_next_nonseq;
          w_first_d  = 1'b0;
          if (r_cnt == 8'd0) begin
            w_state_d = StDrain;
          end else begin
            w_cnt_d = r_cnt - 8'd1;
          end
        end
      end
      StDrain: begin
        w_valid = r_dvalid;
        w_last  = r_dlast;
        if (w_herr) begin
          w_state_d = StErrWait;
        end else if (bus.HREADY) begin
          w_state_d = StIdle;
        end
      end
      StErrWait: begin
        w_valid = r_dvalid;
        w_last  = r_dlast;
        if (bus.HREADY) begin
          w_state_d = r_dlast ? StIdle : StErrFill;
        end
      end
      StErrFill: begin
        w_valid = 1'b1;
        w_err   = 1'b1;
        w_last  = (r_cnt == 8'd0);
        if (bus.HREADY && bus.ctrl_rdata_ready_i) begin
          if (r_cnt == 8'd0) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt - 8'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Data phase follows a completed address phase and holds until HREADY.
    if (w_issue) begin
      w_dvalid_d = 1'b1;
      w_dlast_d  = (r_cnt == 8'd0);
    end else if (bus.HREADY) begin
      w_dvalid_d = 1'b0;
      w_dlast_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_nonseq <= 1'b0;
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_addr   <= w_addr_d;
      r_cnt    <= w_cnt_d;
      r_first  <= w_first_d;
      r_nonseq <= w_nonseq_d;
      r_dvalid <= w_dvalid_d;
      r_dlast  <= w_dlast_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_id    <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (w_capture) begin
      r_id    <= bus.cmd_id_i;
      r_len   <= bus.cmd_len_i;
      r_size  <= w_cmd_size;
      r_burst <= bus.cmd_burst_i;
    end
  end

  assign bus.cmd_ready_o        = (r_state == StIdle) && ARESETN;
  assign bus.HADDR              = r_addr;
  assign bus.HTRANS             = w_htrans;
  assign bus.HWRITE             = 1'b0;
  assign bus.HSIZE              = r_size;
  assign bus.HBURST             = (r_len == 8'd0) ? 3'b000 : 3'b001;
  assign bus.ctrl_rdata_valid_o = w_valid;
  assign bus.ctrl_rdata_last_o  = w_last;
  assign bus.cmd_id_o           = r_id;
  assign bus.cmd_error_o        = w_err;
endmodule

// File: tb/tb_axi2ahb_rctrl.sv
// Bench for axi2ahb_rctrl: a burst-address model and beat scoreboard checked every cycle,
// with literal address/trans logs pinning the directed cases.
module tb_axi2ahb_rctrl;
  localparam int unsigned IdW = 1;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  axi2ahb_rctrl_if #(.AXI_ID_WIDTH(IdW), .AXI_ADDR_WIDTH(AW)) bus ();

  axi2ahb_rctrl #(
    .AXI_ID_WIDTH  (IdW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state for the command in flight.
  logic [AW-1:0]  exp_addr[$];
  bit             exp_ns[$];
  logic [IdW-1:0] exp_id;
  int             exp_len, exp_err_beat, exp_size;
  logic [2:0]     exp_hburst;
  int             beats_seen, issued, err_beats;
  bit             last_done, err_prev, mon_en;
  logic [AW+1:0]  log_q[$];
  logic [AW+1:0]  exp_log[$];
  int             err_beat_cfg = 0;
  int             ws_beat_cfg  = 0;
  int             err_step     = 0;

  task automatic model_cmd(input logic [IdW-1:0] id, input logic [AW-1:0] a, input int len,
                           input int size, input int burst, input int err_beat);
    longint unsigned sz, total, base, ai, prev, a64;
    bit wrap;
    int n;
    sz    = 64'd1 << size;
    total = longint'(len + 1) * sz;
    a64   = longint'(a);
    base  = (a64 / total) * total;
    wrap  = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
    n     = (err_beat != 0) ? err_beat : len + 1;
    prev  = 0;
    exp_addr.delete();
    exp_ns.delete();
    log_q.delete();
    for (int i = 0; i < n; i++) begin
      if (burst == 0)  ai = a64;
      else if (wrap)   ai = base + ((a64 - base + longint'(i) * sz) % total);
      else             ai = a64 + longint'(i) * sz;
      exp_addr.push_back(AW'(ai));
      exp_ns.push_back(i == 0 || ai != prev + sz || (ai >> 10) != (prev >> 10));
      prev = ai;
    end
    exp_id       = id;
    exp_len      = len;
    exp_size     = size;
    exp_hburst   = (len == 0) ? 3'b000 : 3'b001;
    exp_err_beat = err_beat;
    beats_seen   = 0;
    issued       = 0;
    err_beats    = 0;
    last_done    = 1'b0;
    err_prev     = 1'b0;
  endtask

  // Compare process: every cycle, mid-cycle, against the model.
  logic [AW-1:0] m_a;
  bit            m_ns;
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETN && mon_en) begin
        check("hwrite", bus.HWRITE, 0);
        if (err_prev) check("idle_after_err", bus.HTRANS, 2'b00);
        err_prev  = bus.ctrl_rdata_valid_o && bus.HRESP && !bus.HREADY;
        last_done = 1'b0;
        if (bus.HTRANS == 2'b01) begin
          log_q.push_back({bus.HTRANS, bus.HADDR});
          if (exp_addr.size() == 0) check("extra_busy", bus.HTRANS, 2'b00);
          else check("busy_haddr", bus.HADDR, exp_addr[0]);
        end else if (bus.HTRANS[1] && bus.HREADY) begin
          log_q.push_back({bus.HTRANS, bus.HADDR});
          issued++;
          last_done = 1'b1;
          if (exp_addr.size() == 0) begin
            check("extra_xfer", bus.HTRANS, 2'b00);
          end else begin
            m_a  = exp_addr.pop_front();
            m_ns = exp_ns.pop_front();
            check("haddr", bus.HADDR, m_a);
            check("htrans", bus.HTRANS, m_ns ? 2'b10 : 2'b11);
            check("hsize", bus.HSIZE, exp_size);
            check("hburst", bus.HBURST, exp_hburst);
          end
        end
        if (bus.ctrl_rdata_valid_o && bus.HREADY && (!bus.cmd_error_o || bus.ctrl_rdata_ready_i))
        begin
          beats_seen++;
          check("beat_last", bus.ctrl_rdata_last_o, 64'(beats_seen == exp_len + 1));
          check("beat_id", bus.cmd_id_o, exp_id);
          check("beat_err", bus.cmd_error_o,
                64'(exp_err_beat != 0 && beats_seen > exp_err_beat));
          if (bus.cmd_error_o) err_beats++;
        end
      end
    end
  end

  // AHB slave: optional single wait state or two-cycle error on a chosen beat's data phase.
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      if (err_step == 1) begin
        bus.HRESP = 1'b1;
        err_step  = 0;
      end else if (last_done && err_beat_cfg != 0 && issued == err_beat_cfg) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        err_step   = 1;
      end else if (last_done && ws_beat_cfg != 0 && issued == ws_beat_cfg) begin
        bus.HREADY = 1'b0;
      end
    end
  end

  task automatic issue_cmd(input logic [IdW-1:0] id, input logic [AW-1:0] a, input int len,
                           input int size, input int burst);
    int n;
    @(posedge ACLK);
    #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_id_i    = id;
    bus.cmd_addr_i  = a;
    bus.cmd_len_i   = 8'(len);
    bus.cmd_size_i  = 3'(size);
    bus.cmd_burst_i = 2'(burst);
    n = 0;
    @(negedge ACLK);
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    check("cmd_accept", bus.cmd_ready_o, 1);
    @(posedge ACLK);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input logic [IdW-1:0] id, input logic [AW-1:0] a, input int len,
                         input int size, input int burst, input int err_beat, input int ws);
    int n;
    model_cmd(id, a, len, size, burst, err_beat);
    err_beat_cfg = err_beat;
    ws_beat_cfg  = ws;
    issue_cmd(id, a, len, size, burst);
    n = 0;
    while ((beats_seen < len + 1 || !bus.cmd_ready_o) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("beat_count", beats_seen, len + 1);
    check("addr_left", exp_addr.size(), 0);
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, log_q.size(), exp_log.size());
    for (int i = 0; i < log_q.size() && i < exp_log.size(); i++) check(name, log_q[i], exp_log[i]);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    mon_en                 = 1'b0;
    bus.cmd_valid_i        = 1'b0;
    bus.cmd_id_i           = '0;
    bus.cmd_addr_i         = '0;
    bus.cmd_len_i          = '0;
    bus.cmd_size_i         = '0;
    bus.cmd_burst_i        = '0;
    bus.ctrl_rdata_ready_i = 1'b1;
    repeat (2) @(negedge ACLK);
    check("rst_ready", bus.cmd_ready_o, 0);
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_haddr", bus.HADDR, 0);
    check("rst_valid", bus.ctrl_rdata_valid_o, 0);
    @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("ready_after_rst", bus.cmd_ready_o, 1);
    mon_en = 1'b1;

    // Single beat.
    run_cmd(1'b1, 32'h100, 0, 2, 1, 0, 0);
    exp_log = '{{2'b10, 32'h100}};
    check_log("single_log");

    // INCR4 with downstream back-pressure after the second address.
    fork
      run_cmd(1'b0, 32'h0, 3, 2, 1, 0, 0);
      begin
        n = 0;
        do begin
          @(negedge ACLK);
          #1;
          n++;
        end while (issued < 2 && n < 50);
        @(posedge ACLK);
        #1;
        bus.ctrl_rdata_ready_i = 1'b0;
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        bus.ctrl_rdata_ready_i = 1'b1;
      end
    join
    exp_log = '{{2'b10, 32'h0}, {2'b11, 32'h4}, {2'b01, 32'h8}, {2'b01, 32'h8},
                {2'b11, 32'h8}, {2'b11, 32'hC}};
    check_log("busy_log");

    // WRAP4 crossing the wrap point.
    run_cmd(1'b1, 32'h38, 3, 2, 2, 0, 0);
    exp_log = '{{2'b10, 32'h38}, {2'b11, 32'h3C}, {2'b10, 32'h30}, {2'b11, 32'h34}};
    check_log("wrap_log");

    // INCR across a 1KB boundary, with one wait state on beat 1.
    run_cmd(1'b0, 32'h3F8, 3, 2, 1, 0, 1);
    exp_log = '{{2'b10, 32'h3F8}, {2'b11, 32'h3FC}, {2'b10, 32'h400}, {2'b11, 32'h404}};
    check_log("kb_log");

    // FIXED burst: every beat is NONSEQ at the same address.
    run_cmd(1'b1, 32'h44, 2, 1, 0, 0, 0);
    exp_log = '{{2'b10, 32'h44}, {2'b10, 32'h44}, {2'b10, 32'h44}};
    check_log("fixed_log");

    // INCR4 with an AHB error on beat 2: beats 3-4 synthesised.
    run_cmd(1'b1, 32'h200, 3, 2, 1, 2, 0);
    exp_log = '{{2'b10, 32'h200}, {2'b11, 32'h204}};
    check_log("err_log");
    check("err_beats", err_beats, 2);

    // Error on the final beat: no synthesised beats.
    run_cmd(1'b0, 32'h700, 1, 2, 1, 2, 0);
    check("err_last_beats", err_beats, 0);
    err_beat_cfg = 0;

    // Asynchronous reset during beat 2 of an 8-beat burst.
    model_cmd(1'b1, 32'h500, 7, 2, 1, 0);
    issue_cmd(1'b1, 32'h500, 7, 2, 1);
    n = 0;
    while (issued < 2 && n < 50) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    check("rst_mid_reached", issued, 2);
    @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    check("arst_htrans", bus.HTRANS, 2'b00);
    check("arst_haddr", bus.HADDR, 0);
    check("arst_hsize", bus.HSIZE, 0);
    check("arst_hburst", bus.HBURST, 0);
    check("arst_valid", bus.ctrl_rdata_valid_o, 0);
    check("arst_last", bus.ctrl_rdata_last_o, 0);
    check("arst_id", bus.cmd_id_o, 0);
    check("arst_err", bus.cmd_error_o, 0);
    check("arst_ready", bus.cmd_ready_o, 0);
    repeat (2) @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("ready_after_arst", bus.cmd_ready_o, 1);
    run_cmd(1'b1, 32'h600, 1, 2, 1, 0, 0);
    exp_log = '{{2'b10, 32'h600}, {2'b11, 32'h604}};
    check_log("post_rst_log");

    repeat (3) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
